// File: rtl/tlk2711_pkg.sv
// Shared definitions for the TLK2711 PS-side register path: bus widths,
// AXI response codes and the AXI-Lite bridge state encoding.
package tlk2711_pkg;

  localparam int unsigned REG_ADDR_W = 16;
  localparam int unsigned REG_DATA_W = 64;
  localparam int unsigned REG_STRB_W = REG_DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR_EXEC,
    WR_WAIT,
    WR_RESP,
    RD_WAIT,
    RD_RESP
  } bridge_state_e;

endpackage

// File: rtl/axil_reg_bridge.sv
// AXI4-Lite slave that serialises PS reads/writes onto the register manager's
// simple wen/ren register bus, honouring its fixed read and write latencies.
module axil_reg_bridge
  import tlk2711_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = REG_ADDR_W,
  parameter int unsigned DATA_WIDTH = REG_DATA_W,
  parameter int unsigned RD_LATENCY = 6,
  parameter int unsigned WR_LATENCY = 4
) (
  input  logic                      ps_clk,
  input  logic                      ps_rst_n,
  input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic                      o_reg_wen,
  output logic [ADDR_WIDTH-1:0]     o_reg_waddr,
  output logic [DATA_WIDTH-1:0]     o_reg_wdata,
  output logic                      o_reg_ren,
  output logic [ADDR_WIDTH-1:0]     o_reg_raddr,
  input  logic [DATA_WIDTH-1:0]     i_reg_rdata
);

  localparam int unsigned STRB_W  = DATA_WIDTH / 8;
  localparam int unsigned MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_W - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_LATENCY - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_LATENCY - 1);

  bridge_state_e           state;
  logic                    aw_full, w_full, ar_full;
  logic [ADDR_WIDTH-1:0]   awaddr_q, araddr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_W-1:0]       wstrb_q;
  logic [CNT_W-1:0]        cnt;
  logic                    last_was_write;

  logic aw_hs, w_hs, ar_hs;
  logic grant_wr, grant_rd;
  logic strb_full;

  assign aw_hs     = s_axi_awvalid && s_axi_awready;
  assign w_hs      = s_axi_wvalid  && s_axi_wready;
  assign ar_hs     = s_axi_arvalid && s_axi_arready;
  assign strb_full = &wstrb_q;

  // Round-robin between a complete write and a pending read; writes win first.
  assign grant_wr = aw_full && w_full && (!ar_full || !last_was_write);
  assign grant_rd = ar_full && !grant_wr;

  always_ff @(posedge ps_clk) begin
    if (!ps_rst_n) begin
      state          <= IDLE;
      aw_full        <= 1'b0;
      w_full         <= 1'b0;
      ar_full        <= 1'b0;
      awaddr_q       <= '0;
      araddr_q       <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      cnt            <= '0;
      last_was_write <= 1'b0;
      s_axi_awready  <= 1'b0;
      s_axi_wready   <= 1'b0;
      s_axi_arready  <= 1'b0;
      s_axi_bresp    <= RESP_OKAY;
      s_axi_bvalid   <= 1'b0;
      s_axi_rdata    <= '0;
      s_axi_rresp    <= RESP_OKAY;
      s_axi_rvalid   <= 1'b0;
      o_reg_wen      <= 1'b0;
      o_reg_waddr    <= '0;
      o_reg_wdata    <= '0;
      o_reg_ren      <= 1'b0;
      o_reg_raddr    <= '0;
    end else begin
      if (aw_hs) begin
        aw_full  <= 1'b1;
        awaddr_q <= s_axi_awaddr & ~ALIGN_MASK;
      end
      if (w_hs) begin
        w_full  <= 1'b1;
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
      end
      if (ar_hs) begin
        ar_full  <= 1'b1;
        araddr_q <= s_axi_araddr & ~ALIGN_MASK;
      end

      o_reg_wen <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_wr) begin
            state          <= WR_EXEC;
            last_was_write <= 1'b1;
            s_axi_awready  <= 1'b0;
            s_axi_wready   <= 1'b0;
            s_axi_arready  <= 1'b0;
            // Partial strobes are refused outright: no bus write, SLVERR.
            o_reg_wen      <= strb_full;
            o_reg_waddr    <= awaddr_q;
            o_reg_wdata    <= wdata_q;
            s_axi_bresp    <= strb_full ? RESP_OKAY : RESP_SLVERR;
          end else if (grant_rd) begin
            state          <= RD_WAIT;
            last_was_write <= 1'b0;
            s_axi_awready  <= 1'b0;
            s_axi_wready   <= 1'b0;
            s_axi_arready  <= 1'b0;
            o_reg_ren      <= 1'b1;
            o_reg_raddr    <= araddr_q;
            cnt            <= '0;
          end else begin
            s_axi_awready  <= !(aw_full || aw_hs);
            s_axi_wready   <= !(w_full || w_hs);
            s_axi_arready  <= !(ar_full || ar_hs);
          end
        end

        WR_EXEC: begin
          cnt   <= '0;
          state <= WR_WAIT;
        end

        // Hold off the response until the register manager has absorbed the write.
        WR_WAIT: begin
          if (cnt == WR_LAST) begin
            s_axi_bvalid <= 1'b1;
            state        <= WR_RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        WR_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            aw_full       <= 1'b0;
            w_full        <= 1'b0;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
            s_axi_arready <= !ar_full;
            state         <= IDLE;
          end
        end

        RD_WAIT: begin
          if (cnt == RD_LAST) begin
            o_reg_ren    <= 1'b0;
            s_axi_rdata  <= i_reg_rdata;
            s_axi_rresp  <= RESP_OKAY;
            s_axi_rvalid <= 1'b1;
            state        <= RD_RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RD_RESP: begin
          if (s_axi_rready) begin
            s_axi_rvalid  <= 1'b0;
            ar_full       <= 1'b0;
            s_axi_arready <= 1'b1;
            s_axi_awready <= !aw_full;
            s_axi_wready  <= !w_full;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_reg_bridge.sv
// Directed scoreboard bench for axil_reg_bridge with a behavioural
// register-manager model on the register bus.
module tb_axil_reg_bridge;

  localparam int unsigned RD_LAT = 6;
  localparam int unsigned WR_LAT = 4;

  logic        ps_clk = 1'b0;
  logic        ps_rst_n;
  logic [15:0] s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [63:0] s_axi_wdata;
  logic [7:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [15:0] s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [63:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic        o_reg_wen;
  logic [15:0] o_reg_waddr;
  logic [63:0] o_reg_wdata;
  logic        o_reg_ren;
  logic [15:0] o_reg_raddr;
  logic [63:0] i_reg_rdata;

  always #5 ps_clk = ~ps_clk;

  axil_reg_bridge #(
    .ADDR_WIDTH(16), .DATA_WIDTH(64), .RD_LATENCY(RD_LAT), .WR_LATENCY(WR_LAT)
  ) dut (
    .ps_clk(ps_clk), .ps_rst_n(ps_rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .o_reg_wen(o_reg_wen), .o_reg_waddr(o_reg_waddr), .o_reg_wdata(o_reg_wdata),
    .o_reg_ren(o_reg_ren), .o_reg_raddr(o_reg_raddr), .i_reg_rdata(i_reg_rdata)
  );

  // Register manager model: 32 x 64-bit window at 0x0000-0x00FF, zero elsewhere.
  logic [63:0] rm_mem [0:31];
  always @(posedge ps_clk) begin
    if (!ps_rst_n) begin
      for (int i = 0; i < 32; i++) rm_mem[i] <= 64'd0;
      rm_mem[10] <= 64'hA000_0000_0000_0015;
    end else if (o_reg_wen && o_reg_waddr < 16'h0100) begin
      rm_mem[o_reg_waddr[7:3]] <= o_reg_wdata;
    end
  end
  assign i_reg_rdata = (o_reg_ren && o_reg_raddr < 16'h0100) ? rm_mem[o_reg_raddr[7:3]] : 64'd0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [79:0] exp_wr[$];
  logic [1:0]  exp_b[$];
  logic [63:0] exp_r[$];
  logic        exp_order[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor: pops the scoreboard on each register-bus op and AXI response.
  int          cyc = 0, wen_cyc = 0, ren_len = 0;
  logic        wen_pending = 1'b0, ren_d = 1'b0, bvalid_d = 1'b0;
  logic        bstall = 1'b0, rstall = 1'b0;
  logic [1:0]  bresp_prev = 2'b00;
  logic [63:0] rdata_prev = 64'd0;
  logic [79:0] e_wr;

  always @(negedge ps_clk) begin
    if (!ps_rst_n) begin
      ren_len = 0; ren_d = 1'b0; bvalid_d = 1'b0;
      bstall = 1'b0; rstall = 1'b0; wen_pending = 1'b0;
    end else begin
      cyc++;
      if (o_reg_wen) begin
        chk("wen_ren_overlap", 64'(o_reg_ren), 64'd0);
        chk("wen_expected", 64'(exp_wr.size() > 0), 64'd1);
        if (exp_wr.size() > 0) begin
          e_wr = exp_wr.pop_front();
          chk("waddr", 64'(o_reg_waddr), 64'(e_wr[79:64]));
          chk("wdata", o_reg_wdata, e_wr[63:0]);
        end
        chk("order_wr_expected", 64'(exp_order.size() > 0), 64'd1);
        if (exp_order.size() > 0) chk("order_wr", 64'(exp_order.pop_front()), 64'd0);
        wen_cyc = cyc; wen_pending = 1'b1;
      end
      if (o_reg_ren && !ren_d) begin
        chk("order_rd_expected", 64'(exp_order.size() > 0), 64'd1);
        if (exp_order.size() > 0) chk("order_rd", 64'(exp_order.pop_front()), 64'd1);
      end
      if (o_reg_ren) ren_len++;
      if (!o_reg_ren && ren_d) begin
        chk("ren_length", 64'(ren_len), 64'(RD_LAT));
        ren_len = 0;
      end
      ren_d = o_reg_ren;

      if (s_axi_bvalid && !bvalid_d && wen_pending) begin
        chk("b_latency", 64'(cyc - wen_cyc), 64'(WR_LAT + 1));
        wen_pending = 1'b0;
      end
      bvalid_d = s_axi_bvalid;

      if (bstall) begin
        chk("bvalid_hold", 64'(s_axi_bvalid), 64'd1);
        chk("bresp_hold", 64'(s_axi_bresp), 64'(bresp_prev));
      end
      if (rstall) begin
        chk("rvalid_hold", 64'(s_axi_rvalid), 64'd1);
        chk("rdata_hold", s_axi_rdata, rdata_prev);
      end
      bstall = s_axi_bvalid && !s_axi_bready; bresp_prev = s_axi_bresp;
      rstall = s_axi_rvalid && !s_axi_rready; rdata_prev = s_axi_rdata;

      if (s_axi_bvalid && s_axi_bready) begin
        chk("b_expected", 64'(exp_b.size() > 0), 64'd1);
        if (exp_b.size() > 0) chk("bresp", 64'(s_axi_bresp), 64'(exp_b.pop_front()));
      end
      if (s_axi_rvalid && s_axi_rready) begin
        chk("r_expected", 64'(exp_r.size() > 0), 64'd1);
        if (exp_r.size() > 0) chk("rdata", s_axi_rdata, exp_r.pop_front());
        chk("rresp", 64'(s_axi_rresp), 64'd0);
      end
    end
  end

  task automatic send_aw(input logic [15:0] a);
    logic done = 1'b0;
    s_axi_awaddr = a; s_axi_awvalid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge ps_clk);
      if (s_axi_awready) begin @(posedge ps_clk); #1; done = 1'b1; end
    end
    s_axi_awvalid = 1'b0;
    chk("aw_accept", 64'(done), 64'd1);
  endtask

  task automatic send_w(input logic [63:0] d, input logic [7:0] s);
    logic done = 1'b0;
    s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge ps_clk);
      if (s_axi_wready) begin @(posedge ps_clk); #1; done = 1'b1; end
    end
    s_axi_wvalid = 1'b0;
    chk("w_accept", 64'(done), 64'd1);
  endtask

  task automatic send_ar(input logic [15:0] a);
    logic done = 1'b0;
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge ps_clk);
      if (s_axi_arready) begin @(posedge ps_clk); #1; done = 1'b1; end
    end
    s_axi_arvalid = 1'b0;
    chk("ar_accept", 64'(done), 64'd1);
  endtask

  task automatic push_write(input logic [15:0] a, input logic [63:0] d, input logic [7:0] s);
    if (s == 8'hFF) begin
      exp_wr.push_back({a & 16'hFFF8, d});
      exp_order.push_back(1'b0);
    end
    exp_b.push_back((s == 8'hFF) ? 2'b00 : 2'b10);
  endtask

  task automatic push_read(input logic [63:0] d);
    exp_r.push_back(d);
    exp_order.push_back(1'b1);
  endtask

  task automatic drive_write(input logic [15:0] a, input logic [63:0] d,
                             input logic [7:0] s, input int w_lead);
    fork
      send_w(d, s);
      begin
        if (w_lead > 0) begin repeat (w_lead) @(posedge ps_clk); #1; end
        send_aw(a);
      end
    join
  endtask

  task automatic axi_write(input logic [15:0] a, input logic [63:0] d, input logic [7:0] s);
    push_write(a, d, s);
    drive_write(a, d, s, 0);
  endtask

  task automatic axi_read(input logic [15:0] a, input logic [63:0] d);
    push_read(d);
    send_ar(a);
  endtask

  task automatic wait_idle();
    logic done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge ps_clk);
      done = (exp_b.size() == 0) && (exp_r.size() == 0) && !s_axi_bvalid && !s_axi_rvalid;
    end
    chk("drain", 64'(exp_b.size() + exp_r.size()), 64'd0);
    @(posedge ps_clk); #1;
  endtask

  task automatic wait_sig(input string tag, input int which);
    logic seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge ps_clk);
      seen = (which == 0) ? s_axi_bvalid : (which == 1) ? s_axi_rvalid : o_reg_ren;
    end
    chk(tag, 64'(seen), 64'd1);
  endtask

  initial begin
    ps_rst_n = 1'b0;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0;
    s_axi_araddr = '0; s_axi_arvalid = 1'b0;
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    repeat (3) @(posedge ps_clk);
    @(negedge ps_clk);
    chk("rst_awready", 64'(s_axi_awready), 64'd0);
    chk("rst_wready", 64'(s_axi_wready), 64'd0);
    chk("rst_arready", 64'(s_axi_arready), 64'd0);
    chk("rst_valids", 64'({s_axi_bvalid, s_axi_rvalid, o_reg_wen, o_reg_ren}), 64'd0);
    chk("rst_rdata", s_axi_rdata, 64'd0);
    chk("rst_bresp", 64'(s_axi_bresp), 64'd0);
    @(posedge ps_clk); #1;
    ps_rst_n = 1'b1;

    axi_write(16'h0020, 64'h0000_0000_8000_0000, 8'hFF);
    wait_idle();
    axi_read(16'h0050, 64'hA000_0000_0000_0015);
    wait_idle();

    push_write(16'h002D, 64'h1111_2222_3333_4444, 8'hFF);
    drive_write(16'h002D, 64'h1111_2222_3333_4444, 8'hFF, 3);
    wait_idle();

    axi_write(16'h0030, 64'hDEAD_BEEF_0000_0001, 8'h0F);
    wait_idle();
    axi_read(16'h0030, 64'd0);
    wait_idle();
    axi_read(16'h0020, 64'h0000_0000_8000_0000);
    wait_idle();

    // Simultaneous write and read, twice: writes go first and the read sees them.
    for (int k = 0; k < 2; k++) begin
      logic [15:0] a;
      logic [63:0] d;
      a = 16'h0040 + 16'(k * 8);
      d = 64'h5A5A_0000_0000_0000 | 64'(k + 1);
      push_write(a, d, 8'hFF);
      push_read(d);
      fork
        drive_write(a, d, 8'hFF, 0);
        send_ar(a);
      join
      wait_idle();
    end

    s_axi_bready = 1'b0;
    axi_write(16'h0058, 64'hCAFE_F00D_1234_5678, 8'hFF);
    wait_sig("bvalid_seen", 0);
    repeat (10) @(posedge ps_clk);
    #1 s_axi_bready = 1'b1;
    wait_idle();

    s_axi_rready = 1'b0;
    axi_read(16'h0058, 64'hCAFE_F00D_1234_5678);
    wait_sig("rvalid_seen", 1);
    repeat (10) @(posedge ps_clk);
    #1 s_axi_rready = 1'b1;
    wait_idle();

    axi_read(16'h8000, 64'd0);
    wait_idle();

    // Reset during RD_WAIT: read is abandoned, no response afterwards.
    axi_read(16'h0050, 64'hA000_0000_0000_0015);
    wait_sig("ren_seen", 2);
    repeat (2) @(posedge ps_clk);
    #1 ps_rst_n = 1'b0;
    exp_r.delete();
    @(posedge ps_clk);
    @(negedge ps_clk);
    chk("rst_mid_ren", 64'(o_reg_ren), 64'd0);
    chk("rst_mid_rvalid", 64'(s_axi_rvalid), 64'd0);
    @(posedge ps_clk); #1;
    ps_rst_n = 1'b1;
    repeat (20) @(posedge ps_clk);
    @(negedge ps_clk);
    chk("post_rst_rvalid", 64'(s_axi_rvalid), 64'd0);
    chk("queues_empty", 64'(exp_wr.size() + exp_b.size() + exp_r.size() + exp_order.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_reg_bridge.md
Name: axil_reg_bridge

Overview:
- AXI4-Lite slave that converts PS master transactions (64-bit data, 16-bit address) into the simple register bus used by the TLK2711 register manager.
- Register bus signals: wen/waddr/wdata and ren/raddr/rdata.
- Sits directly upstream of the register manager, on the PS side.
- Serialises reads and writes, holds read requests for the register manager's fixed pipeline latency, and returns AXI responses.

Parameters:
- ADDR_WIDTH, 16, AXI and register-bus address width.
- DATA_WIDTH, 64, AXI and register-bus data width; only 64 is supported.
- RD_LATENCY, 6, number of cycles o_reg_ren/o_reg_raddr are held before i_reg_rdata is sampled; must be ≥ 2.
- WR_LATENCY, 4, number of cycles after the o_reg_wen pulse before bvalid asserts; guarantees write-then-read coherency.

Ports:
- ps_clk  in  1  sole clock.
- ps_rst_n  in  1  synchronous, active-low reset.
- s_axi_awaddr  in  16  write address.
- s_axi_awvalid  in  1  write address valid.
- s_axi_awready  out  1  write address ready.
- s_axi_wdata  in  64  write data.
- s_axi_wstrb  in  8  write strobes.
- s_axi_wvalid  in  1  write data valid.
- s_axi_wready  out  1  write data ready.
- s_axi_bresp  out  2  write response.
- s_axi_bvalid  out  1  write response valid.
- s_axi_bready  in  1  write response ready.
- s_axi_araddr  in  16  read address.
- s_axi_arvalid  in  1  read address valid.
- s_axi_arready  out  1  read address ready.
- s_axi_rdata  out  64  read data.
- s_axi_rresp  out  2  read response.
- s_axi_rvalid  out  1  read data valid.
- s_axi_rready  in  1  read data ready.
- o_reg_wen  out  1  single-cycle write strobe.
- o_reg_waddr  out  16  write address, 8-byte aligned.
- o_reg_wdata  out  64  write data.
- o_reg_ren  out  1  read request, held.
- o_reg_raddr  out  16  read address, 8-byte aligned.
- i_reg_rdata  in  64  read data from register manager.

Behaviour:
- Clocking and reset: ps_clk only; ps_rst_n is synchronous, active-low.
- Outputs held at 0 while ps_rst_n=0:
  - all ready and valid outputs;
  - o_reg_wen, o_reg_ren;
  - addr, data and resp registers;
  - counters; FSM goes to IDLE.
- Reset asserted mid-transaction aborts it immediately: no response is issued and ren drops the next cycle.
- AW/W capture:
  - awready=1 when the AW holding register is empty and state is IDLE; W capture works the same way, independently.
  - AW and W may arrive in either order or in the same cycle; each is latched on its valid&ready handshake.
  - addr[2:0] is forced to 0 on latch.
- AR capture: arready=1 when state is IDLE and no AR is pending; latched on handshake.
- FSM states: IDLE, WR_EXEC, WR_WAIT, WR_RESP, RD_WAIT, RD_RESP.
- IDLE arbitration, when both a complete write (AW and W both held) and an AR are pending:
  - round-robin using a last_was_write flag; the flag resets to 0, so the first conflict goes to the write;
  - otherwise the single pending request is served.
- IDLE → WR_EXEC, for exactly one cycle:
  - if wstrb == 8'hFF: o_reg_wen=1 with o_reg_waddr/o_reg_wdata valid, and response SLVERR is not flagged;
  - otherwise: no wen, and bresp=2'b10 (SLVERR) is flagged.
- WR_EXEC → WR_WAIT: counter runs from 0 to WR_LATENCY-1.
- WR_WAIT → WR_RESP: bvalid=1 and held until bready; then the AW/W holding registers are cleared and state returns to IDLE.
- IDLE → RD_WAIT:
  - o_reg_ren=1 and o_reg_raddr stable for exactly RD_LATENCY cycles;
  - on the last cycle, i_reg_rdata is registered into s_axi_rdata.
- RD_WAIT → RD_RESP: ren=0, rvalid=1 and held until rready, with rresp=2'b00; then the AR register is cleared and state returns to IDLE.
- Out-of-window addresses return whatever the register manager drives (0) with OKAY; the bridge does no decode.
- Data stability: s_axi_rdata and s_axi_bresp are stable while valid=1 and ready=0.
- Concurrency: at most one register-bus operation is outstanding; o_reg_wen and o_reg_ren are never high together.
- Minimum throughput:
  - a write takes 1 + WR_LATENCY + 1 cycles from IDLE to its bvalid handshake;
  - a read takes RD_LATENCY + 1 cycles.
- Counters are $clog2(max(RD_LATENCY, WR_LATENCY)+1) bits wide and never wrap.

Decomposition:
- Shared package tlk2711_pkg holds:
  - FSM state enum;
  - AXI response constants (RESP_OKAY=2'b00, RESP_SLVERR=2'b10);
  - register-bus widths.
- No sub-module: a single flat module.

Test Plan:
- Write addr 0x0020, data 0x0000_0000_8000_0000, wstrb FF → one o_reg_wen pulse with waddr 0x0020; bvalid arrives WR_LATENCY+1 cycles after the pulse, bresp=00.
- Read addr 0x0050 with model rdata 0xA000_0000_0000_0015 → o_reg_ren held 6 cycles; s_axi_rdata=0xA000_0000_0000_0015, rresp=00.
- W presented 3 cycles before AW, addr 0x002D → o_reg_waddr=0x0028; exactly one wen.
- wstrb=0x0F → no o_reg_wen; bresp=10.
- Write and read valid in the same cycle, repeated twice → order is write, read, write, read; wen and ren never overlap.
- bready/rready held low 10 cycles → bvalid/rvalid and data held stable; ps_rst_n=0 during RD_WAIT → ren=0 and rvalid=0 the next cycle, with no response afterwards.
